// File: rtl/sink_table_writer_pkg.sv
// Constants and state encoding shared by the sink-table writer, the amISink
// reader and the testbench.
package sink_table_writer_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int ADDR_STEP  = 2;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRCOUNT,
    DONE
  } state_t;

endpackage

// File: rtl/sink_table_writer.sv
// Writes a stream of sink IDs into shared memory as a length-prefixed table;
// the count word goes last so a reader never sees it cover unwritten entries.
module sink_table_writer #(
  parameter int WORD_WIDTH = sink_table_writer_pkg::WORD_WIDTH,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_STEP  = sink_table_writer_pkg::ADDR_STEP,
  parameter int MAX_SINKS  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [WORD_WIDTH-1:0] id_in,
  input  logic                  id_valid,
  input  logic                  id_last,
  output logic                  id_ready,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  import sink_table_writer_pkg::*;

  localparam int                    CW   = $clog2(MAX_SINKS + 1);
  localparam logic [WORD_WIDTH-1:0] BASE = WORD_WIDTH'(BASE_ADDR);
  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(ADDR_STEP);
  localparam logic [CW-1:0]         MAXC = CW'(MAX_SINKS);

  state_t                state;
  logic [CW-1:0]         count;
  logic [WORD_WIDTH-1:0] entry_addr;

  // Entry slots start one word past the count word.
  assign entry_addr = BASE + STEP * (WORD_WIDTH'(count) + WORD_WIDTH'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      id_ready    <= 1'b0;
      address     <= BASE;
      wr_en       <= 1'b0;
      mem_data_in <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count    <= '0;
            overflow <= 1'b0;
            id_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= COLLECT;
          end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= WRCOUNT;
          end
        end
        COLLECT: begin
          if (id_valid && id_ready) begin
            // Beyond MAX_SINKS the ID is still accepted so the source drains.
            if (count < MAXC) begin
              wr_en       <= 1'b1;
              address     <= entry_addr;
              mem_data_in <= id_in;
              count       <= count + CW'(1);
            end else begin
              overflow <= 1'b1;
            end
            if (id_last) begin
              id_ready <= 1'b0;
              state    <= WRCOUNT;
            end
          end
        end
        WRCOUNT: begin
          wr_en       <= 1'b1;
          address     <= BASE;
          mem_data_in <= WORD_WIDTH'(count);
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          id_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
